// File: rtl/seq_alu.sv
// Multi-cycle sign-magnitude ALU: add/sub/and in one cycle,
// shift-add multiply and restoring divide one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int M  = WIDTH - 1;
    localparam int PW = 2 * M;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] CMD_ADD   = 3'd0;
    localparam logic [2:0] CMD_SUB   = 3'd1;
    localparam logic [2:0] CMD_AND   = 3'd2;
    localparam logic [2:0] CMD_MULHI = 3'd3;
    localparam logic [2:0] CMD_MULLO = 3'd4;
    localparam logic [2:0] CMD_DIV   = 3'd5;
    localparam logic [2:0] CMD_MOD   = 3'd6;

    localparam logic [CNT_W-1:0] CNT_M   = CNT_W'(M);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [M-1:0]     mplier_q, mplier_d;
    logic [M-1:0]     rem_q, rem_d;
    logic [M-1:0]     quo_q, quo_d;
    logic [M-1:0]     dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       flags_q, flags_d;

    logic             accept;
    logic [M-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0] c_val, d_val;
    logic [WIDTH:0]   add_s, sub_s;
    logic             add_ovf, sub_ovf;
    logic             d_zero;

    logic [PW-1:0]      mul_acc_nx;
    logic [2*WIDTH-1:0] prod_ext, prod_s;

    logic [M:0]       trial;
    logic             ge;
    logic [M-1:0]     rem_nx, quo_nx;
    logic [WIDTH-1:0] q_ext, r_ext, q_s, r_s;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign accept    = in_valid && in_ready;

    // Sign-magnitude to two's complement; negative zero folds to 0.
    always_comb begin
        a_mag = a[M-1:0];
        b_mag = b[M-1:0];
        c_val = {1'b0, a_mag};
        d_val = {1'b0, b_mag};
        if (a[WIDTH-1]) c_val = WIDTH'(0) - {1'b0, a_mag};
        if (b[WIDTH-1]) d_val = WIDTH'(0) - {1'b0, b_mag};
        d_zero = (b_mag == '0);
    end

    always_comb begin
        add_s   = {c_val[WIDTH-1], c_val} + {d_val[WIDTH-1], d_val};
        sub_s   = {c_val[WIDTH-1], c_val} - {d_val[WIDTH-1], d_val};
        add_ovf = add_s[WIDTH] ^ add_s[WIDTH-1];
        sub_ovf = sub_s[WIDTH] ^ sub_s[WIDTH-1];
    end

    always_comb begin
        mul_acc_nx = acc_q;
        if (mplier_q[0]) mul_acc_nx = acc_q + mcand_q;
        prod_ext = {2'b00, mul_acc_nx};
        prod_s   = prod_ext;
        if (sa_q ^ sb_q) prod_s = ~prod_ext + 1'b1;
    end

    // One restoring step; remainder stays below the divisor so M bits hold it.
    always_comb begin
        trial  = {rem_q, quo_q[M-1]};
        ge     = (trial >= {1'b0, dvsr_q});
        rem_nx = trial[M-1:0];
        if (ge) rem_nx = trial[M-1:0] - dvsr_q;
        quo_nx = {quo_q[M-2:0], ge};
        q_ext  = {1'b0, quo_nx};
        r_ext  = {1'b0, rem_nx};
        q_s    = q_ext;
        r_s    = r_ext;
        if (sa_q ^ sb_q) q_s = ~q_ext + 1'b1;
        if (sa_q) r_s = ~r_ext + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d   = command;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    flags_d = '0;
                    cnt_d   = '0;
                    case (command)
                        CMD_ADD: begin
                            result_d   = add_s[WIDTH-1:0];
                            flags_d[0] = add_ovf;
                            state_d    = S_DONE;
                        end
                        CMD_SUB: begin
                            result_d   = sub_s[WIDTH-1:0];
                            flags_d[0] = sub_ovf;
                            state_d    = S_DONE;
                        end
                        CMD_AND: begin
                            result_d = c_val & d_val;
                            state_d  = S_DONE;
                        end
                        CMD_MULHI, CMD_MULLO: begin
                            acc_d    = '0;
                            mcand_d  = {{M{1'b0}}, a_mag};
                            mplier_d = b_mag;
                            cnt_d    = CNT_M;
                            state_d  = S_MUL;
                        end
                        CMD_DIV, CMD_MOD: begin
                            if (d_zero) begin
                                result_d   = '0;
                                flags_d[1] = 1'b1;
                                state_d    = S_DONE;
                            end else begin
                                rem_d   = '0;
                                quo_d   = a_mag;
                                dvsr_d  = b_mag;
                                cnt_d   = CNT_M;
                                state_d = S_DIV;
                            end
                        end
                        default: begin
                            result_d   = '0;
                            flags_d[2] = 1'b1;
                            state_d    = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = mul_acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (cmd_q == CMD_MULHI) result_d = prod_s[2*WIDTH-1:WIDTH];
                    else result_d = prod_s[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    if (cmd_q == CMD_MOD) result_d = r_s;
                    else result_d = q_s;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table plus backpressure
// and mid-divide reset sequences.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  command;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one op, count edges until out_valid (acceptance edge = 1).
    task automatic issue(input logic [2:0] c, input logic [15:0] av,
                         input logic [15:0] bv, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        command  = c;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_drain", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{3'd0, 16'h0005, 16'h8003, 16'h0002, 3'b000, 1};
        vecs[1]  = '{3'd1, 16'h0005, 16'h8003, 16'h0008, 3'b000, 1};
        vecs[2]  = '{3'd0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b001, 1};
        vecs[3]  = '{3'd0, 16'h8000, 16'h0000, 16'h0000, 3'b000, 1};
        vecs[4]  = '{3'd2, 16'h00F0, 16'h8001, 16'h00F0, 3'b000, 1};
        vecs[5]  = '{3'd1, 16'h8000, 16'h7FFF, 16'h8001, 3'b000, 1};
        vecs[6]  = '{3'd1, 16'h8002, 16'h7FFF, 16'h7FFF, 3'b001, 1};
        vecs[7]  = '{3'd4, 16'h0003, 16'h8004, 16'hFFF4, 3'b000, 16};
        vecs[8]  = '{3'd3, 16'h0003, 16'h8004, 16'hFFFF, 3'b000, 16};
        vecs[9]  = '{3'd3, 16'h7FFF, 16'h7FFF, 16'h3FFF, 3'b000, 16};
        vecs[10] = '{3'd4, 16'h7FFF, 16'h7FFF, 16'h0001, 3'b000, 16};
        vecs[11] = '{3'd5, 16'h8007, 16'h0002, 16'hFFFD, 3'b000, 16};
        vecs[12] = '{3'd6, 16'h8007, 16'h0002, 16'hFFFF, 3'b000, 16};
        vecs[13] = '{3'd5, 16'h0009, 16'h8000, 16'h0000, 3'b010, 1};
        vecs[14] = '{3'd6, 16'h0009, 16'h0000, 16'h0000, 3'b010, 1};
        vecs[15] = '{3'd7, 16'h1234, 16'h0001, 16'h0000, 3'b100, 1};
        vecs[16] = '{3'd5, 16'h7FFF, 16'h0003, 16'h2AAA, 3'b000, 16};
        vecs[17] = '{3'd6, 16'h7FFF, 16'h0003, 16'h0001, 3'b000, 16};
        vecs[18] = '{3'd5, 16'h0007, 16'h8003, 16'hFFFE, 3'b000, 16};
        vecs[19] = '{3'd6, 16'h0007, 16'h8003, 16'h0001, 3'b000, 16};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        command   = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
            drain();
        end

        // Backpressure: result held, second request not taken.
        issue(3'd4, 16'h0003, 16'h8004, lat);
        check("bp_latency", 32'(lat), 32'd16);
        command  = 3'd0;
        a        = 16'h0001;
        b        = 16'h0001;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_result", 32'(result), 32'h0000FFF4);
            check("bp_flags", 32'(flags), 32'd0);
            check("bp_hold", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_accept", {30'd0, out_valid, in_ready}, 32'd1);
        check("bp_result_kept", 32'(result), 32'h0000FFF4);

        // Reset mid-divide.
        @(negedge clk);
        command  = 3'd5;
        a        = 16'h8007;
        b        = 16'h0002;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("div_busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_div", {30'd0, out_valid, in_ready}, 32'd1);
        check("rst_mid_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 16'h0001, 16'h0001, lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        check("post_rst_result", 32'(result), 32'h00000002);
        check("post_rst_flags", 32'(flags), 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
